// File: rtl/msm_bf_issuer_if.sv
// Request/response handshake bundle between the MSM controller and the butterfly issuer.
// The controller is the master (drives requests, accepts responses); the issuer is the slave.
interface msm_bf_issuer_if #(
  parameter int DATA_W = 384,
  parameter int TAG_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_op, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_op, rsp_data, rsp_tag
  );
endinterface

// File: rtl/msm_bf_issuer.sv
// MSM-side issuer for the 384-bit butterfly: issues tagged add/mul requests, equalises both
// ops to MUL_LAT cycles, and returns results in order through a credit-protected FIFO.
module msm_bf_issuer #(
  parameter int DATA_W     = 384,
  parameter int MUL_LAT    = 6,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msm_en,
  msm_bf_issuer_if.slave    bus,
  output logic              busy,
  output logic              flag_msm,
  output logic [DATA_W-1:0] msm_add_a,
  output logic [DATA_W-1:0] msm_add_b,
  output logic [DATA_W-1:0] msm_mul_a,
  output logic [DATA_W-1:0] msm_mul_b,
  input  logic [DATA_W-1:0] add_o,
  input  logic [DATA_W-1:0] mul_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic              valid;
    logic              op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] add_result;
  } stage_t;

  typedef struct packed {
    logic              op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  stage_t           pipe [MUL_LAT];
  rsp_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, outstanding;
  logic             issue, pop, done, mul_pending;
  rsp_t             done_entry, head;

  // Credits cover both in-flight ops and queued responses, so the FIFO can never overflow.
  assign bus.req_ready = msm_en & flag_msm & (outstanding < CNT_W'(FIFO_DEPTH));
  assign issue         = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign busy          = (outstanding != '0);

  // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    msm_add_a = '0;
    msm_add_b = '0;
    msm_mul_a = '0;
    msm_mul_b = '0;
    if (issue) begin
      if (bus.req_op) begin
        msm_mul_a = bus.req_a;
        msm_mul_b = bus.req_b;
      end else begin
        msm_add_a = bus.req_a;
        msm_add_b = bus.req_b;
      end
    end
  end

  // The last stage is excluded: its mul_o is already on the bus, so the mode may drop next cycle.
  always_comb begin
    mul_pending = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++)
      mul_pending = mul_pending | (pipe[k].valid & pipe[k].op);
  end

  assign done            = pipe[MUL_LAT-1].valid;
  assign done_entry.op   = pipe[MUL_LAT-1].op;
  assign done_entry.tag  = pipe[MUL_LAT-1].tag;
  assign done_entry.data = pipe[MUL_LAT-1].op ? mul_o : pipe[MUL_LAT-1].add_result;

  // NOTE: sequential state is written with non-blocking assignments only, so stage k reads the old stage k-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{valid:      issue,
                   op:         bus.req_op,
                   tag:        bus.req_tag,
                   add_result: (issue && !bus.req_op) ? add_o : '0};
      for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // NOTE: the storage array is not reset; occupancy lives in the pointers and the empty head reads as 0.
  always_ff @(posedge clk) begin
    if (done) fifo_mem[wr_ptr] <= done_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      flag_msm    <= 1'b0;
    end else begin
      assert (!(done && (fifo_cnt == CNT_W'(FIFO_DEPTH)) && !pop));
      if (done) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt    <= fifo_cnt + CNT_W'(done) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(pop);
      flag_msm    <= msm_en | mul_pending;
    end
  end

  assign head          = fifo_mem[rd_ptr];
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_op    = bus.rsp_valid ? head.op   : 1'b0;
  assign bus.rsp_tag   = bus.rsp_valid ? head.tag  : '0;
endmodule

// File: tb/tb_msm_bf_issuer.sv
// Directed bench for msm_bf_issuer with a behavioural butterfly (combinational add,
// MUL_LAT-deep multiply). Inputs change 1 time unit after each rising edge.
module tb_msm_bf_issuer;
  localparam int DATA_W     = 384;
  localparam int MUL_LAT    = 6;
  localparam int TAG_W      = 8;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              msm_en;
  logic              busy, flag_msm;
  logic [DATA_W-1:0] msm_add_a, msm_add_b, msm_mul_a, msm_mul_b;
  logic [DATA_W-1:0] add_o, mul_o;
  logic [DATA_W-1:0] mul_dl [MUL_LAT];

  int n_checks = 0;
  int n_errors = 0;
  int accepted, seen, n;

  msm_bf_issuer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  msm_bf_issuer #(
    .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .msm_en(msm_en), .bus(bus),
    .busy(busy), .flag_msm(flag_msm),
    .msm_add_a(msm_add_a), .msm_add_b(msm_add_b),
    .msm_mul_a(msm_mul_a), .msm_mul_b(msm_mul_b),
    .add_o(add_o), .mul_o(mul_o)
  );

  always #5 clk = ~clk;

  // Butterfly model: add is combinational, mul appears MUL_LAT cycles after its operands.
  assign add_o = msm_add_a + msm_add_b;
  always @(posedge clk) begin
    mul_dl[0] <= msm_mul_a * msm_mul_b;
    for (int k = 1; k < MUL_LAT; k++) mul_dl[k] <= mul_dl[k-1];
  end
  assign mul_o = mul_dl[MUL_LAT-1];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input int a, input int b, input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = DATA_W'(a);
    bus.req_b     = DATA_W'(b);
    bus.req_tag   = tag;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
  endtask

  task automatic expect_rsp(input string tag, input int data, input logic op, input logic [TAG_W-1:0] rtag);
    check({tag, "_valid"}, DATA_W'(bus.rsp_valid), 1);
    check({tag, "_data"},  bus.rsp_data, DATA_W'(data));
    check({tag, "_op"},    DATA_W'(bus.rsp_op), DATA_W'(op));
    check({tag, "_tag"},   DATA_W'(bus.rsp_tag), DATA_W'(rtag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: every output 0 while rst is high.
    rst = 1'b1; msm_en = 1'b0; bus.rsp_ready = 1'b1; idle();
    tick(); tick();
    check("rst_req_ready", DATA_W'(bus.req_ready), 0);
    check("rst_rsp_valid", DATA_W'(bus.rsp_valid), 0);
    check("rst_rsp_data",  bus.rsp_data, 0);
    check("rst_rsp_op",    DATA_W'(bus.rsp_op), 0);
    check("rst_rsp_tag",   DATA_W'(bus.rsp_tag), 0);
    check("rst_busy",      DATA_W'(busy), 0);
    check("rst_flag",      DATA_W'(flag_msm), 0);
    check("rst_ops",       msm_add_a | msm_add_b | msm_mul_a | msm_mul_b, 0);

    // msm_en at cycle 0 -> req_ready at cycle 1.
    rst = 1'b0; msm_en = 1'b1; #1;
    check("en_c0_ready", DATA_W'(bus.req_ready), 0);
    tick();
    check("en_c1_flag",  DATA_W'(flag_msm), 1);
    check("en_c1_ready", DATA_W'(bus.req_ready), 1);

    // Single mul 3*5, tag 0x11, response at t+7.
    send(1'b1, 3, 5, 8'h11); #1;
    check("mul_drive_a", msm_mul_a, 3);
    check("mul_drive_b", msm_mul_b, 5);
    check("mul_add_zero", msm_add_a | msm_add_b, 0);
    tick(); idle(); #1;
    check("mul_idle_ops", msm_mul_a | msm_mul_b, 0);
    check("mul_busy", DATA_W'(busy), 1);
    repeat (5) tick();
    check("mul_t6_valid", DATA_W'(bus.rsp_valid), 0);
    tick();
    expect_rsp("mul_t7", 15, 1'b1, 8'h11);
    tick();
    check("mul_popped_valid", DATA_W'(bus.rsp_valid), 0);
    check("mul_popped_busy",  DATA_W'(busy), 0);

    // Mixed back-to-back add/mul/add: 3, 8, 7 in consecutive cycles from t+7.
    send(1'b0, 1, 2, 8'h01); #1;
    check("mix_add_drive", msm_add_a, 1);
    tick(); send(1'b1, 2, 4, 8'h02);
    tick(); send(1'b0, 7, 0, 8'h03);
    tick(); idle();
    repeat (4) tick();
    expect_rsp("mix_r0", 3, 1'b0, 8'h01);
    tick();
    expect_rsp("mix_r1", 8, 1'b1, 8'h02);
    tick();
    expect_rsp("mix_r2", 7, 1'b0, 8'h03);
    tick();
    check("mix_drained", DATA_W'(bus.rsp_valid), 0);

    // Backpressure: 10 cycles of offers with rsp_ready=0 -> exactly 8 accepted.
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      send(1'b0, accepted, 100, TAG_W'(8'h20 + accepted)); #1;
      if (bus.req_ready) accepted++;
      tick();
    end
    send(1'b0, accepted, 100, TAG_W'(8'h20 + accepted)); #1;
    check("bp_accepted", DATA_W'(accepted), 8);
    check("bp_ready_low", DATA_W'(bus.req_ready), 0);
    // One pop frees exactly one credit.
    bus.rsp_ready = 1'b1; #1;
    expect_rsp("bp_pop0", 100, 1'b0, 8'h20);
    tick(); bus.rsp_ready = 1'b0; #1;
    check("bp_credit_ready", DATA_W'(bus.req_ready), 1);
    tick();
    send(1'b0, 9, 100, 8'h29); #1;
    check("bp_ready_again_low", DATA_W'(bus.req_ready), 0);
    tick(); idle();
    // Drain: entries 1..8 in order, nothing duplicated.
    bus.rsp_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n = 0;
      while (!bus.rsp_valid && n < 20) begin tick(); n++; end
      expect_rsp("bp_drain", i + 100, 1'b0, TAG_W'(8'h20 + i));
      tick();
    end
    check("bp_empty", DATA_W'(bus.rsp_valid), 0);
    check("bp_not_busy", DATA_W'(busy), 0);

    // Mode drop one cycle after a mul issue.
    send(1'b1, 6, 7, 8'h55);
    tick(); idle(); msm_en = 1'b0; #1;
    check("drop_ready", DATA_W'(bus.req_ready), 0);
    check("drop_flag_t1", DATA_W'(flag_msm), 1);
    repeat (5) tick();
    check("drop_flag_t6", DATA_W'(flag_msm), 1);
    tick();
    check("drop_flag_t7", DATA_W'(flag_msm), 0);
    expect_rsp("drop_rsp", 42, 1'b1, 8'h55);
    tick();
    check("drop_drained", DATA_W'(busy), 0);

    // Reset with 4 in flight and 3 in the FIFO.
    msm_en = 1'b1; bus.rsp_ready = 1'b0;
    tick();
    for (int j = 0; j < 7; j++) begin
      send(1'b0, j, 1, TAG_W'(8'h40 + j));
      tick();
    end
    idle();
    tick(); tick();
    check("mid_pre_valid", DATA_W'(bus.rsp_valid), 1);
    check("mid_pre_busy",  DATA_W'(busy), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", DATA_W'(bus.rsp_valid), 0);
    check("mid_rst_busy",  DATA_W'(busy), 0);
    rst = 1'b0; bus.rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    check("mid_no_stale", DATA_W'(seen), 0);
    send(1'b1, 9, 9, 8'h77);
    tick(); idle();
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    expect_rsp("mid_fresh", 81, 1'b1, 8'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/msm_bf_issuer.md
# msm_bf_issuer

MSM-side request issuer and response collector for the configurable 384-bit butterfly. It accepts tagged add/mul requests over valid/ready and drives the butterfly's MSM operand ports and its `flag_msm` mode select. It captures the butterfly's `add_o`/`mul_o` at fixed latency and returns results in order through a credit-protected response FIFO. It is the initiator end of the butterfly's MSM port; the MSM point-arithmetic controller sits upstream.

## Interface
Parameters:
- `DATA_W`, 384, operand/result width.
- `MUL_LAT`, 6, cycles from operands on `msm_mul_*` to valid `mul_o`; must be ≥1.
- `TAG_W`, 8, request tag width.
- `FIFO_DEPTH`, 8, response FIFO entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `msm_en`  in  1  request MSM mode.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_op`  in  1  0 = modular add, 1 = modular mul.
- `req_a`, `req_b`  in  DATA_W  operands.
- `req_tag`  in  TAG_W  opaque tag, returned with the result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response popped when `rsp_valid & rsp_ready`.
- `rsp_data`  out  DATA_W  result.
- `rsp_op`, `rsp_tag`  out  1 / TAG_W  echo of the request.
- `busy`  out  1  requests in flight or FIFO non-empty.
- `flag_msm`  out  1  butterfly mode select, registered.
- `msm_add_a`, `msm_add_b`, `msm_mul_a`, `msm_mul_b`  out  DATA_W  butterfly operands.
- `add_o`, `mul_o`  in  DATA_W  butterfly results; `add_o` is combinational, `mul_o` arrives MUL_LAT cycles after its operands.

## Operation
- **Mode register.** `flag_msm` sets the cycle after `msm_en`=1. It clears only when `msm_en`=0 and no mul is in flight, so `flag_384` is stable for every in-flight mul.
- **Issue condition.** `req_ready` = `msm_en & flag_msm & (outstanding < FIFO_DEPTH)`. It is combinational from registers and `msm_en`, and never depends on `req_valid`.
- **Operand drive.** On an issue cycle:
  - add: `msm_add_a/b` = `req_a/b`, `msm_mul_*` = 0.
  - mul: `msm_mul_a/b` = `req_a/b`, `msm_add_*` = 0.
  - No issue: all four are 0.
- **Uniform-latency pipeline.**
  - Each issue enters a MUL_LAT-deep shift pipeline carrying {valid, op, tag, add_result}.
  - `add_result` captures `add_o` in the issue cycle (0 for mul).
  - At the last stage, data = `mul_o` if op=1, else the delayed `add_result`.
  - Every op completes exactly MUL_LAT cycles after issue, so completion order equals issue order: at most one completion per cycle, no reordering.
- **Response FIFO.**
  - A completing stage writes {data, op, tag} into the FIFO.
  - The head drives `rsp_*`, and `rsp_valid` = FIFO non-empty.
  - Overflow is impossible by credit; write-when-full is a design error and is asserted in simulation.
- **Outstanding counter** (0..FIFO_DEPTH) counts in-flight entries plus FIFO entries:
  - +1 on issue.
  - −1 on pop.
  - Unchanged on simultaneous issue and pop.
- **`busy`** = outstanding ≠ 0.
- **Mode drop.** With `msm_en` dropped mid-stream, in-flight ops still complete and enter the FIFO. Responses keep draining regardless of `msm_en`.
- **Reset.** Reset in the middle of operation discards pipeline and FIFO contents with no partial response; the butterfly's own pipeline contents are ignored.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_op`=0, `rsp_tag`=0, `busy`=0, `flag_msm`=0, all `msm_*` operands 0, outstanding=0, pipeline valids 0, FIFO empty.
- First issue is possible in cycle e+1, where `msm_en` first goes high in cycle e.
- Issue in cycle t → FIFO write at the end of cycle t+MUL_LAT → `rsp_valid` in cycle t+MUL_LAT+1. Minimum request-to-response latency is MUL_LAT+1.
- Throughput is one request per cycle while credits remain. With `rsp_ready` held at 1, back-to-back issue sustains indefinitely.
- FIFO with simultaneous read and write when full: legal, no loss, occupancy unchanged.
- `flag_msm` falls in the cycle after the last mul completes while `msm_en`=0. It falls the cycle after `msm_en`=0 if nothing is in flight.
- `rsp_*` hold stable while `rsp_valid & ~rsp_ready`.

## Test plan
- **Reset.** Reset, then `msm_en`=1 at cycle 0 → `req_ready` goes 1 at cycle 1, and every output is 0 while `rst`=1.
- **Single mul.** Mul with a=3, b=5, tag=0x11 at cycle t; the model butterfly returns `mul_o`=15 at t+6 → `rsp_valid` at t+7 with data=15, op=1, tag=0x11.
- **Mixed in-order.** Back-to-back add(1,2,tag 1), mul(2,4,tag 2), add(7,0,tag 3) → three responses in consecutive cycles from t+7, in order 3, 8, 7.
- **Backpressure.** `rsp_ready`=0 and 10 requests offered → exactly 8 accepted, `req_ready`=0 thereafter. Then a single pop → exactly one further accept next cycle; no data lost or duplicated.
- **Mode drop.** `msm_en` dropped one cycle after a mul issue → `req_ready` goes 0 immediately, `flag_msm` stays 1 until that mul completes then falls, and the response is still delivered.
- **Reset mid-stream.** `rst` with 4 in flight and 3 in the FIFO → next cycle `rsp_valid`=0, `busy`=0, and no stale responses after `msm_en` is re-enabled.
